psum_accum_wb: RTL and testbench
================================

Name: psum_accum_wb

Overview:
- Output-side stage that sits directly downstream of the corelet OFIFO.
- Pops one col-wide psum vector at a time from the OFIFO and reads the matching partial-sum vector from the psum SRAM.
- Adds the two per column with signed saturation and writes the result back to the same SRAM address.
- On the final accumulation pass it optionally applies ReLU before the write. It replaces host-driven OFIFO draining during conv tiling.

Parameters:
- col, 8, number of columns / psum lanes per vector
- psum_bw, 16, bit width of each signed psum lane
- addr_bw, 11, psum SRAM address width

Ports:
- clk  input  1  clock; all logic is rising-edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse that begins a pass; ignored unless the block is IDLE
- base_addr  input  addr_bw  first psum SRAM address of the pass; latched at start
- num_vec  input  addr_bw  number of vectors to process; latched at start
- first_pass  input  1  when 1, the SRAM operand is treated as 0 and no SRAM read is issued; latched at start
- relu_en  input  1  when 1, negative results are clamped to 0 before the write; latched at start
- ofifo_o_valid  input  1  OFIFO holds at least one vector
- ofifo_out  input  col*psum_bw  OFIFO head vector, combinational
- ofifo_rd  output  1  pop strobe to the OFIFO
- psum_cen  output  1  SRAM chip enable, active low
- psum_wen  output  1  SRAM write enable, active low
- psum_addr  output  addr_bw  SRAM address
- psum_d  output  col*psum_bw  SRAM write data
- psum_q  input  col*psum_bw  SRAM read data, valid one cycle after a read (cen=0, wen=1)
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when a pass completes

Behaviour:
- FSM states: IDLE, FETCH, WAIT, WRITE, DONE.
- Reset (synchronous): the FSM goes to IDLE and the vector counter clears. All outputs take their reset values: ofifo_rd=0, psum_cen=1, psum_wen=1, psum_addr=0, psum_d=0, busy=0, done=0.
- IDLE:
  - On start=1, latch base_addr, num_vec, first_pass and relu_en, and clear the counter.
  - If num_vec==0, go to DONE; otherwise go to FETCH.
- FETCH: wait for ofifo_o_valid.
  - In the cycle it is 1: assert ofifo_rd=1 for exactly that cycle and capture ofifo_out into a vector register.
  - In that same cycle drive psum_addr=base_addr+cnt and psum_wen=1, with psum_cen=0 unless first_pass (then psum_cen=1).
  - Next state is WAIT.
- While ofifo_o_valid=0, hold in FETCH with ofifo_rd=0 and psum_cen=1. There is no timeout.
- WAIT:
  - Capture psum_q; the captured value is forced to 0 if first_pass.
  - psum_cen=1. Next state is WRITE.
- WRITE:
  - Drive psum_cen=0, psum_wen=0, psum_addr=base_addr+cnt, and psum_d = per-lane result.
  - Next state: if cnt==num_vec-1, go to DONE; otherwise increment cnt and go to FETCH.
- DONE: done=1 for one cycle; next state is IDLE.
- Per-lane arithmetic:
  - Compute sum = ofifo lane + SRAM lane, signed, at psum_bw+1 bits.
  - Saturate to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
  - If relu_en and the saturated result is negative, the result is 0.
  - Lane i occupies bits [psum_bw*(i+1)-1 : psum_bw*i] on all vector buses.
- Address wrap: base_addr+cnt is computed modulo 2^addr_bw; wrap is legal and silent.
- Throughput is 1 vector per 3 cycles when the OFIFO never runs empty. Latency from the ofifo_rd cycle to the SRAM write cycle is 2 clocks.
- Port ordering: ofifo_rd is never asserted when ofifo_o_valid=0. Read and write never occur in the same cycle.
- start while busy is ignored, and the latched config is unaffected.
- Reset mid-pass: the block returns to IDLE on the next edge. The in-flight write is dropped and no partial write is issued in the reset cycle. OFIFO contents already popped are lost, which is acceptable.
- Between passes, psum_cen stays 1 and psum_d/psum_addr hold their last values. Neither the host nor the bench may rely on their values while cen=1.

Test Plan:
- First pass: start with base_addr=0x010, num_vec=3, first_pass=1, relu_en=0; OFIFO supplies vectors with all lanes =5, -7, 100.
  - Required: no SRAM reads.
  - Required: writes at 0x010/0x011/0x012 with lanes 5/-7/100 (0xFFF9 for -7).
  - Required: done pulses once, 3 cycles after the last write cycle's FETCH.
- Accumulate with saturation: SRAM lane0=0x7FF0, lane1=0x8005; OFIFO lane0=0x0020, lane1=0xFFF0; first_pass=0.
  - Required: written lane0=0x7FFF, lane1=0x8000; other lanes are the plain sum.
- ReLU: SRAM lanes = -10, 3; OFIFO lanes = 4, 4; relu_en=1.
  - Required: written lanes are 0 and 7.
- OFIFO stall: num_vec=2, with ofifo_o_valid held low for 5 cycles after the first vector.
  - Required: FSM holds in FETCH, ofifo_rd=0 and psum_cen=1 throughout; the second vector completes correctly; exactly 2 pops in total.
- Control corners:
  - start with num_vec=0 -> done the next cycle and no SRAM or OFIFO activity.
  - start pulsed mid-pass -> ignored.
  - base_addr=0x7FF, num_vec=2 -> writes at 0x7FF then 0x000.
- Reset mid-pass: assert reset during WAIT.
  - Required: next cycle busy=0, psum_cen=1, psum_wen=1, ofifo_rd=0, no write issued.
  - Required: a following start runs a full pass normally.

Source files
------------

// File: rtl/psum_accum_wb.sv
// psum_accum_wb: drains the corelet OFIFO one vector at a time.
// Each popped vector is added lane by lane to the matching psum SRAM vector
// (signed, saturating), optionally passed through ReLU, and written back in place.
module psum_accum_wb #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_bw = 11
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [addr_bw-1:0]        base_addr,
    input  logic [addr_bw-1:0]        num_vec,
    input  logic                      first_pass,
    input  logic                      relu_en,
    input  logic                      ofifo_o_valid,
    input  logic [col*psum_bw-1:0]    ofifo_out,
    output logic                      ofifo_rd,
    output logic                      psum_cen,
    output logic                      psum_wen,
    output logic [addr_bw-1:0]        psum_addr,
    output logic [col*psum_bw-1:0]    psum_d,
    input  logic [col*psum_bw-1:0]    psum_q,
    output logic                      busy,
    output logic                      done
);

    localparam logic signed [psum_bw-1:0] SAT_MAX = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic signed [psum_bw-1:0] SAT_MIN = {1'b1, {(psum_bw-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, WRITE, DONE} state_t;

    state_t state, state_nx;

    logic [addr_bw-1:0]     num_r;
    logic [addr_bw-1:0]     cnt;
    logic [addr_bw-1:0]     addr_r;
    logic                   first_r;
    logic                   relu_r;
    logic                   last_vec;
    logic [col*psum_bw-1:0] vec_p0;
    logic [col*psum_bw-1:0] sum_p1;

    // Add at psum_bw+1 bits; the two top bits disagree exactly on overflow.
    function automatic logic signed [psum_bw-1:0] sat_add(
        input logic signed [psum_bw-1:0] a,
        input logic signed [psum_bw-1:0] b
    );
        logic signed [psum_bw:0] s;
        s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
        if (s[psum_bw] != s[psum_bw-1])
            return s[psum_bw] ? SAT_MIN : SAT_MAX;
        return s[psum_bw-1:0];
    endfunction

    function automatic logic signed [psum_bw-1:0] relu(
        input logic signed [psum_bw-1:0] x,
        input logic                      en
    );
        return (en && x[psum_bw-1]) ? '0 : x;
    endfunction

    assign last_vec  = (cnt == num_r - addr_bw'(1));
    assign psum_addr = addr_r;

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Pass configuration, vector counter and running SRAM address (wraps mod 2^addr_bw).
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            addr_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        num_r   <= num_vec;
                        first_r <= first_pass;
                        relu_r  <= relu_en;
                        cnt     <= '0;
                        addr_r  <= base_addr;
                    end
                end
                WRITE: begin
                    if (!last_vec) begin
                        cnt    <= cnt + addr_bw'(1);
                        addr_r <= addr_r + addr_bw'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p0: capture the OFIFO head in the pop cycle.
    always_ff @(posedge clk) begin
        if (state == FETCH && ofifo_o_valid)
            vec_p0 <= ofifo_out;
    end

    // Stage p1: per-lane saturating add of the popped vector and the SRAM operand.
    always_comb begin
        logic signed [psum_bw-1:0] a;
        logic signed [psum_bw-1:0] b;
        sum_p1 = '0;
        for (int i = 0; i < col; i++) begin
            a = vec_p0[i*psum_bw +: psum_bw];
            b = first_r ? '0 : psum_q[i*psum_bw +: psum_bw];
            sum_p1[i*psum_bw +: psum_bw] = relu(sat_add(a, b), relu_r);
        end
    end

    // Stage p2: write-data register, loaded at the end of WAIT and held between passes.
    always_ff @(posedge clk) begin
        if (reset)
            psum_d <= '0;
        else if (state == WAIT)
            psum_d <= sum_p1;
    end

    // Next-state and strobe decode; reset suppresses every port strobe in its own cycle.
    always_comb begin
        state_nx = state;
        ofifo_rd = 1'b0;
        psum_cen = 1'b1;
        psum_wen = 1'b1;
        busy     = (state != IDLE);
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nx = (num_vec == '0) ? DONE : FETCH;
            end
            FETCH: begin
                if (ofifo_o_valid) begin
                    ofifo_rd = 1'b1;
                    psum_cen = first_r;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                state_nx = WRITE;
            end
            WRITE: begin
                psum_cen = 1'b0;
                psum_wen = 1'b0;
                state_nx = last_vec ? DONE : FETCH;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (reset) begin
            ofifo_rd = 1'b0;
            psum_cen = 1'b1;
            psum_wen = 1'b1;
        end
    end

endmodule

// File: tb/tb_psum_accum_wb.sv
// Directed bench for psum_accum_wb with an OFIFO model and a one-cycle-latency SRAM model.
module tb_psum_accum_wb;

    localparam int COL = 8;
    localparam int PBW = 16;
    localparam int ABW = 11;
    localparam int W   = COL * PBW;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [ABW-1:0] base_addr;
    logic [ABW-1:0] num_vec;
    logic           first_pass;
    logic           relu_en;
    logic           ofifo_o_valid;
    logic [W-1:0]   ofifo_out;
    logic           ofifo_rd;
    logic           psum_cen;
    logic           psum_wen;
    logic [ABW-1:0] psum_addr;
    logic [W-1:0]   psum_d;
    logic [W-1:0]   psum_q;
    logic           busy;
    logic           done;

    int n_vec  = 0;
    int n_miss = 0;

    psum_accum_wb #(.col(COL), .psum_bw(PBW), .addr_bw(ABW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .num_vec       (num_vec),
        .first_pass    (first_pass),
        .relu_en       (relu_en),
        .ofifo_o_valid (ofifo_o_valid),
        .ofifo_out     (ofifo_out),
        .ofifo_rd      (ofifo_rd),
        .psum_cen      (psum_cen),
        .psum_wen      (psum_wen),
        .psum_addr     (psum_addr),
        .psum_d        (psum_d),
        .psum_q        (psum_q),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // OFIFO model: pushed by the stimulus, popped on ofifo_rd.
    logic [W-1:0] fifo_mem [0:15];
    int wp = 0;
    int rp = 0;
    assign ofifo_o_valid = (wp != rp);
    assign ofifo_out     = fifo_mem[rp[3:0]];

    // SRAM model plus activity counters.
    logic [W-1:0]   mem [0:2047];
    logic           ld_en = 1'b0;
    logic [ABW-1:0] ld_addr = '0;
    logic [W-1:0]   ld_data = '0;
    int cyc = 0, n_wr = 0, n_rd = 0, n_pop = 0, n_done = 0, n_viol = 0;
    int last_rd_cyc = 0, done_cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ld_en)
            mem[ld_addr] <= ld_data;
        else if (psum_cen === 1'b0 && psum_wen === 1'b0) begin
            mem[psum_addr] <= psum_d;
            n_wr <= n_wr + 1;
        end
        if (psum_cen === 1'b0 && psum_wen === 1'b1) begin
            psum_q <= mem[psum_addr];
            n_rd   <= n_rd + 1;
        end
        if (ofifo_rd === 1'b1) begin
            if (ofifo_o_valid) rp <= rp + 1;
            else n_viol <= n_viol + 1;
            n_pop       <= n_pop + 1;
            last_rd_cyc <= cyc;
        end
        if (done === 1'b1) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rep(input logic [PBW-1:0] x);
        return {COL{x}};
    endfunction

    function automatic logic [W-1:0] mk2(input logic [PBW-1:0] l0, input logic [PBW-1:0] l1,
                                         input logic [PBW-1:0] rest);
        return {{(COL-2){rest}}, l1, l0};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [W-1:0] v);
        fifo_mem[wp[3:0]] = v;
        wp = wp + 1;
    endtask

    task automatic preload(input logic [ABW-1:0] a, input logic [W-1:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic pulse_start(input logic [ABW-1:0] b, input logic [ABW-1:0] n,
                               input logic fp, input logic re);
        base_addr  = b;
        num_vec    = n;
        first_pass = fp;
        relu_en    = re;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            if (done === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        check(tag, W'(seen), W'(1));
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int wr0, rd0, pop0, dn0, bad;
        bit seen;
        reset = 1'b1; start = 1'b0; base_addr = '0; num_vec = '0;
        first_pass = 1'b0; relu_en = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst busy", W'(busy), W'(0));
        check("rst cen",  W'(psum_cen), W'(1));
        check("rst wen",  W'(psum_wen), W'(1));
        check("rst rd",   W'(ofifo_rd), W'(0));
        check("rst addr", W'(psum_addr), W'(0));
        check("rst d",    psum_d, W'(0));
        check("rst done", W'(done), W'(0));

        // First pass: no reads, values pass straight through.
        wr0 = n_wr; rd0 = n_rd; dn0 = n_done;
        push(rep(16'd5)); push(rep(16'hFFF9)); push(rep(16'd100));
        pulse_start(11'h010, 11'd3, 1'b1, 1'b0);
        wait_done("fp done");
        check("fp reads",  W'(n_rd - rd0), W'(0));
        check("fp writes", W'(n_wr - wr0), W'(3));
        check("fp dones",  W'(n_done - dn0), W'(1));
        check("fp lat",    W'(done_cyc - last_rd_cyc), W'(3));
        check("fp m010",   mem[11'h010], rep(16'd5));
        check("fp m011",   mem[11'h011], rep(16'hFFF9));
        check("fp m012",   mem[11'h012], rep(16'd100));

        // Saturating accumulate.
        preload(11'h020, mk2(16'h7FF0, 16'h8005, 16'h0100));
        rd0 = n_rd;
        push(mk2(16'h0020, 16'hFFF0, 16'h0003));
        pulse_start(11'h020, 11'd1, 1'b0, 1'b0);
        wait_done("sat done");
        check("sat reads", W'(n_rd - rd0), W'(1));
        check("sat m020",  mem[11'h020], mk2(16'h7FFF, 16'h8000, 16'h0103));

        // ReLU on final pass.
        preload(11'h030, mk2(16'hFFF6, 16'h0003, 16'h0010));
        push(mk2(16'h0004, 16'h0004, 16'h0001));
        pulse_start(11'h030, 11'd1, 1'b0, 1'b1);
        wait_done("relu done");
        check("relu m030", mem[11'h030], mk2(16'h0000, 16'h0007, 16'h0011));

        // OFIFO stall between two vectors.
        wr0 = n_wr; pop0 = n_pop;
        push(rep(16'h1111));
        pulse_start(11'h040, 11'd2, 1'b1, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            if (n_wr - wr0 == 1) seen = 1'b1;
            else @(negedge clk);
        end
        check("stall first wr", W'(seen), W'(1));
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (ofifo_rd !== 1'b0 || psum_cen !== 1'b1 || busy !== 1'b1) bad++;
            tick(1);
        end
        check("stall hold", W'(bad), W'(0));
        push(rep(16'h2222));
        wait_done("stall done");
        check("stall m040", mem[11'h040], rep(16'h1111));
        check("stall m041", mem[11'h041], rep(16'h2222));
        check("stall pops", W'(n_pop - pop0), W'(2));

        // num_vec == 0: done next cycle, no port activity.
        wr0 = n_wr; rd0 = n_rd; pop0 = n_pop;
        pulse_start(11'h100, 11'd0, 1'b0, 1'b0);
        check("nv0 done", W'(done), W'(1));
        tick(1);
        check("nv0 idle", W'(busy), W'(0));
        check("nv0 act",  W'((n_wr - wr0) + (n_rd - rd0) + (n_pop - pop0)), W'(0));

        // start while busy is ignored.
        preload(11'h060, rep(16'hBEEF));
        wr0 = n_wr; dn0 = n_done;
        push(rep(16'h0001)); push(rep(16'h0002));
        pulse_start(11'h050, 11'd2, 1'b1, 1'b0);
        tick(2);
        pulse_start(11'h060, 11'd5, 1'b0, 1'b1);
        wait_done("mid done");
        tick(3);
        check("mid m050",   mem[11'h050], rep(16'h0001));
        check("mid m051",   mem[11'h051], rep(16'h0002));
        check("mid m060",   mem[11'h060], rep(16'hBEEF));
        check("mid writes", W'(n_wr - wr0), W'(2));
        check("mid dones",  W'(n_done - dn0), W'(1));
        check("mid idle",   W'(busy), W'(0));

        // Address wrap.
        push(rep(16'h0AAA)); push(rep(16'h0BBB));
        pulse_start(11'h7FF, 11'd2, 1'b1, 1'b0);
        wait_done("wrap done");
        check("wrap m7FF", mem[11'h7FF], rep(16'h0AAA));
        check("wrap m000", mem[11'h000], rep(16'h0BBB));

        // Reset asserted during WAIT.
        preload(11'h070, rep(16'h0001));
        wr0 = n_wr;
        push(rep(16'h0777));
        pulse_start(11'h070, 11'd1, 1'b0, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (ofifo_rd === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        check("rstm pop", W'(seen), W'(1));
        tick(1);
        reset = 1'b1;
        tick(1);
        check("rstm busy", W'(busy), W'(0));
        check("rstm cen",  W'(psum_cen), W'(1));
        check("rstm wen",  W'(psum_wen), W'(1));
        check("rstm rd",   W'(ofifo_rd), W'(0));
        reset = 1'b0;
        tick(2);
        check("rstm nowr", W'(n_wr - wr0), W'(0));
        check("rstm m070", mem[11'h070], rep(16'h0001));
        push(rep(16'h0123));
        pulse_start(11'h071, 11'd1, 1'b1, 1'b0);
        wait_done("rstm done");
        check("rstm m071", mem[11'h071], rep(16'h0123));

        check("rd when empty", W'(n_viol), W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
